// File: rtl/fetch_buffer_pkg.sv
// Shared widths, constants, FSM encoding and FIFO entry layout for the fetch buffer.
package fetch_buffer_pkg;
  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;

  localparam logic [INST_W-1:0] NOP_INST    = 32'h0000_0000;
  localparam logic              RST_ENABLE  = 1'b1;
  localparam logic              CHIP_ENABLE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [INST_ADDR_W-1:0] pc;
    logic [INST_W-1:0]      inst;
    logic                   adel;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched instructions with flush; head entry read combinationally.
module fetch_fifo
  import fetch_buffer_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  localparam int PTR_W = $clog2(FIFO_DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  fetch_entry_t     push_entry,
  output logic [CNT_W-1:0] count,
  output fetch_entry_t     head_entry
);
  fetch_entry_t     mem_q [FIFO_DEPTH];
  fetch_entry_t     mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // When full, push and pop share a slot; the head is read from mem_q so it is unaffected.
      if (push) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count      = count_q;
  assign head_entry = mem_q[rd_ptr_q];
endmodule

// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: single outstanding imem request, FIFO to decode, flush handling.
// Optional FETCH_ALIGN_CHECK_EN: misaligned fetch addresses bypass memory and queue an adel entry.
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INST_ADDR_W-1:0] pc_i,
  input  logic                   ce_i,
  input  logic                   flush_i,
  output logic                   bbl_o,
  output logic                   imem_req,
  output logic [INST_ADDR_W-1:0] imem_addr,
  input  logic                   imem_ack,
  input  logic [INST_W-1:0]      imem_rdata,
  input  logic                   id_ready,
  output logic                   id_valid,
  output logic [INST_ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0]      id_inst,
  output logic                   id_adel
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e           state_q, state_d;
  logic [INST_ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [CNT_W-1:0]       count;
  logic                   rst_active, misalign, space_ok;
  logic                   push_mem, push_align, push, pop, issue;
  fetch_entry_t           push_entry, head_entry;

  assign rst_active = (rst == RST_ENABLE);

`ifdef FETCH_ALIGN_CHECK_EN
  assign misalign = (pc_i[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    push_mem   = 1'b0;
    pop        = 1'b0;
    space_ok   = 1'b0;
    issue      = 1'b0;
    push_align = 1'b0;
    if (!rst_active) begin
      push_mem = (state_q == ST_BUSY) && imem_ack && !flush_i;
      pop      = id_valid && id_ready && !flush_i;
      space_ok = (int'(count) + int'(push_mem) - int'(pop)) < FIFO_DEPTH;
      // A misaligned fetch waits for the memory to go idle so it cannot overtake or collide with a push.
      issue    = (ce_i == CHIP_ENABLE) && !flush_i && space_ok &&
                 ((state_q == ST_IDLE) || imem_ack) &&
                 !(misalign && (state_q != ST_IDLE));
      push_align = issue && misalign;
    end
    push = push_mem || push_align;
    if (push_align) push_entry = '{pc: pc_i, inst: NOP_INST, adel: 1'b1};
    else            push_entry = '{pc: imem_addr_q, inst: imem_rdata, adel: 1'b0};
  end

  // imem_addr_q doubles as the tag pc of the outstanding request.
  always_comb begin
    state_d     = state_q;
    imem_addr_d = imem_addr_q;
    if (flush_i) begin
      if (state_q != ST_IDLE) state_d = imem_ack ? ST_IDLE : ST_DROP;
    end else if (issue && !misalign) begin
      state_d     = ST_BUSY;
      imem_addr_d = pc_i;
    end else if ((state_q != ST_IDLE) && imem_ack) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_active) begin
      state_q     <= ST_IDLE;
      imem_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      imem_addr_q <= imem_addr_d;
    end
  end

  fetch_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst_active),
    .push       (push),
    .pop        (pop),
    .flush      (flush_i),
    .push_entry (push_entry),
    .count      (count),
    .head_entry (head_entry)
  );

  assign bbl_o     = !issue;
  assign imem_req  = (state_q != ST_IDLE);
  assign imem_addr = imem_addr_q;
  assign id_valid  = (count != '0);
  assign id_pc     = head_entry.pc;
  assign id_inst   = head_entry.inst;
  assign id_adel   = head_entry.adel;
endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: queue-based reference model plus directed scenarios.
module tb_fetch_buffer;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_i = 32'h0;
  logic        ce_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        bbl_o;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        id_ready = 1'b0;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_adel;

  always #5 clk = ~clk;

  fetch_buffer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_i       (pc_i),
    .ce_i       (ce_i),
    .flush_i    (flush_i),
    .bbl_o      (bbl_o),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .id_ready   (id_ready),
    .id_valid   (id_valid),
    .id_pc      (id_pc),
    .id_inst    (id_inst),
    .id_adel    (id_adel)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // Memory responder: acks after ack_delay waiting cycles; spur forces an unsolicited ack.
  int   ack_delay = 0;
  int   wait_cnt  = 0;
  logic spur      = 1'b0;
  initial forever begin
    @(posedge clk);
    #2;
    if (imem_req) begin
      if (wait_cnt >= ack_delay) begin
        imem_ack   = 1'b1;
        imem_rdata = inst_of(imem_addr);
        wait_cnt   = 0;
      end else begin
        imem_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      imem_ack = 1'b0;
      wait_cnt = 0;
    end
    if (spur) imem_ack = 1'b1;
  end

  // Reference model: the buffered entries as a queue, plus the outstanding request.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adel;
  } ent_t;

  ent_t        mq[$];
  bit          m_out, m_drop;
  logic [31:0] m_addr;
  bit          m_push, m_pop, m_issue, m_mis;
  int          m_sz;
  int          cyc, first_valid, bbl_cnt, acc_cnt;
  logic [31:0] pop_log[$];

  initial forever begin
    @(negedge clk);
    if (rst) begin
      chk("bbl_in_reset", 32'(bbl_o), 32'd1);
      mq.delete();
      m_out = 0; m_drop = 0; m_addr = 32'h0;
      cyc = -1; first_valid = -1; bbl_cnt = 0; acc_cnt = 0;
      pop_log.delete();
    end else begin
      cyc++;
      m_sz   = mq.size();
      m_push = m_out && !m_drop && imem_ack && !flush_i;
      m_pop  = (m_sz > 0) && id_ready && !flush_i;
`ifdef FETCH_ALIGN_CHECK_EN
      m_mis  = (pc_i[1:0] != 2'b00);
`else
      m_mis  = 1'b0;
`endif
      m_issue = ce_i && !flush_i && (!m_out || imem_ack) &&
                ((m_sz + int'(m_push) - int'(m_pop)) < DEPTH) && !(m_mis && m_out);
      chk("bbl_o", 32'(bbl_o), 32'(!m_issue));
      chk("imem_req", 32'(imem_req), 32'(m_out));
      chk("imem_addr", imem_addr, m_addr);
      chk("id_valid", 32'(id_valid), 32'(m_sz > 0));
      if (m_sz > 0) begin
        chk("id_pc", id_pc, mq[0].pc);
        chk("id_inst", id_inst, mq[0].inst);
        chk("id_adel", 32'(id_adel), 32'(mq[0].adel));
      end
      if (id_valid && first_valid < 0) first_valid = cyc;
      if (ce_i && bbl_o) bbl_cnt++;
      if (ce_i && !bbl_o) acc_cnt++;
      if (id_valid && id_ready && !flush_i) pop_log.push_back(id_pc);
      if (flush_i) begin
        mq.delete();
        if (m_out && imem_ack) begin m_out = 0; m_drop = 0; end
        else if (m_out) m_drop = 1;
      end else begin
        if (m_pop) void'(mq.pop_front());
        if (m_push) mq.push_back('{pc: m_addr, inst: inst_of(m_addr), adel: 1'b0});
        if (m_issue && m_mis) mq.push_back('{pc: pc_i, inst: 32'h0, adel: 1'b1});
        else if (m_issue) begin m_out = 1; m_drop = 0; m_addr = pc_i; end
        else if (m_out && imem_ack) begin m_out = 0; m_drop = 0; end
      end
    end
  end

  function automatic logic [31:0] pl(input int i);
    if (i < pop_log.size()) return pop_log[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic do_reset();
    rst = 1'b1; ce_i = 1'b1; pc_i = 32'h0; flush_i = 1'b0;
    id_ready = 1'b1; ack_delay = 0; spur = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_id_valid", 32'(id_valid), 32'd0);
    chk("rst_id_pc", id_pc, 32'h0);
    chk("rst_id_inst", id_inst, 32'h0);
    chk("rst_id_adel", 32'(id_adel), 32'd0);
    spur = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic run(input int n);
    bit acc;
    repeat (n) begin
      @(negedge clk); #1;
      acc = ce_i && !bbl_o;
      @(posedge clk); #1;
      if (acc) pc_i += 32'd4;
    end
  endtask

  initial begin
    int  stable;
    bit  acc, pf;

    // Streaming with single-cycle ack
    do_reset();
    run(8);
    chk("t1_first_valid_cycle", 32'(first_valid), 32'd2);
    chk("t1_bbl_cycles", 32'(bbl_cnt), 32'd0);
    chk("t1_pop0", pl(0), 32'h0);
    chk("t1_pop1", pl(1), 32'h4);
    chk("t1_pop2", pl(2), 32'h8);

    // Decode stalled: FIFO fills to depth, then drains in order
    do_reset();
    id_ready = 1'b0;
    run(6);
    chk("t2_accepted", 32'(acc_cnt), 32'd2);
    chk("t2_valid_held", 32'(id_valid), 32'd1);
    id_ready = 1'b1;
    run(6);
    chk("t2_pop0", pl(0), 32'h0);
    chk("t2_pop1", pl(1), 32'h4);
    chk("t2_pop2", pl(2), 32'h8);

    // Slow memory: request held stable until ack
    do_reset();
    ack_delay = 3;
    stable = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      if (c >= 1 && c <= 3 && imem_req && imem_addr == 32'h0 && bbl_o) stable++;
      if (c == 4) begin
        chk("t3_ack_seen", 32'(imem_ack), 32'd1);
        chk("t3_bbl_at_ack", 32'(bbl_o), 32'd0);
      end
      acc = ce_i && !bbl_o;
      @(posedge clk); #1;
      if (acc) pc_i += 32'd4;
    end
    chk("t3_stable_cycles", 32'(stable), 32'd3);
    ce_i = 1'b0;
    run(10);
    chk("t3_pop0", pl(0), 32'h0);
    chk("t3_pop1", pl(1), 32'h4);

    // Flush while the request is outstanding; late data must be dropped
    do_reset();
    ack_delay = 2;
    pc_i = 32'h40;
    @(negedge clk); #1;
    chk("t4_issue_bbl", 32'(bbl_o), 32'd0);
    @(posedge clk); #1;
    flush_i = 1'b1; pc_i = 32'h44;
    @(negedge clk); #1;
    chk("t4_flush_bbl", 32'(bbl_o), 32'd1);
    chk("t4_flush_noack", 32'(imem_ack), 32'd0);
    @(posedge clk); #1;
    flush_i = 1'b0; ce_i = 1'b0;
    @(negedge clk); #1;
    chk("t4_drop_req", 32'(imem_req), 32'd1);
    chk("t4_drop_valid", 32'(id_valid), 32'd0);
    @(posedge clk); #1;
    ce_i = 1'b1; pc_i = 32'h100;
    @(negedge clk); #1;
    chk("t4_late_ack", 32'(imem_ack), 32'd1);
    chk("t4_target_issue", 32'(bbl_o), 32'd0);
    @(posedge clk); #1;
    ce_i = 1'b0;
    run(8);
    chk("t4_pop_count", 32'(pop_log.size()), 32'd1);
    chk("t4_pop0", pl(0), 32'h100);

    // Misaligned fetch address
    do_reset();
    id_ready = 1'b0;
    pc_i = 32'h102;
    @(posedge clk); #1;
    ce_i = 1'b0;
    @(negedge clk); #1;
`ifdef FETCH_ALIGN_CHECK_EN
    chk("t5_no_req", 32'(imem_req), 32'd0);
    chk("t5_valid", 32'(id_valid), 32'd1);
    chk("t5_adel", 32'(id_adel), 32'd1);
    chk("t5_inst", id_inst, 32'h0);
    chk("t5_pc", id_pc, 32'h102);
`else
    chk("t5_req", 32'(imem_req), 32'd1);
    chk("t5_addr", imem_addr, 32'h102);
    @(negedge clk); #1;
    chk("t5_valid", 32'(id_valid), 32'd1);
    chk("t5_adel", 32'(id_adel), 32'd0);
    chk("t5_pc", id_pc, 32'h102);
    chk("t5_inst", id_inst, inst_of(32'h102));
`endif

    // Mixed traffic: backpressure, flushes, varying latency, mid-run reset, stray acks
    do_reset();
    pf = 1'b0;
    for (int i = 0; i < 240; i++) begin
      rst       = (i == 120 || i == 121);
      spur      = (i == 122 || i == 123);
      flush_i   = ((i % 19) == 7) && !rst;
      id_ready  = ((i % 3) != 2);
      ce_i      = ((i % 11) != 4);
      ack_delay = (i / 40) % 3;
      @(negedge clk); #1;
      acc = ce_i && !bbl_o && !rst;
      pf  = flush_i;
      @(posedge clk); #1;
      if (pf) pc_i = (pc_i & 32'hFFFF_FFFC) + 32'h200;
      else if (acc) pc_i += 32'd4;
      if ((i % 23) == 9) pc_i += 32'd2;
    end
    rst = 1'b0; spur = 1'b0; flush_i = 1'b0; ce_i = 1'b0; id_ready = 1'b1;
    run(12);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
